ex_issue_stage: RTL and testbench
=================================

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 The module SHALL have parameter N, default 32: data width of the register file, operands and writeback data.
REQ-002 The module SHALL have parameter REGS, default 16: register count; register address width is clog2(REGS).
REQ-003 The module SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1: decoded instruction present on the in_* ports.
REQ-006 The module SHALL have port in_ready, output, 1: stage accepts the instruction this cycle.
REQ-007 The module SHALL have ports in_rs1 and in_rs2, input, clog2(REGS) each: source register addresses.
REQ-008 The module SHALL have port in_rd, input, clog2(REGS): destination register address.
REQ-009 The module SHALL have port in_imm, input, N: immediate operand.
REQ-010 The module SHALL have port in_use_imm, input, 1: select in_imm instead of register rs2 for operand B.
REQ-011 The module SHALL have port in_aluctl, input, 2: ALU operation (00 add, 01 sub, 10 reserved, 11 left shift).
REQ-012 The module SHALL have ports wb_en (input, 1), wb_addr (input, clog2(REGS)) and wb_data (input, N): register writeback from the downstream result path.
REQ-013 The module SHALL have ports A and B, output, N each: registered ALU operands.
REQ-014 The module SHALL have port ALUControl, output, 2: registered ALU operation.
REQ-015 The module SHALL have ports out_rd (output, clog2(REGS)), out_valid (output, 1) and out_ready (input, 1): issued-instruction handshake.
REQ-016 The module SHALL have port flush, input, 1: discard the held instruction.

Function
REQ-017 The module SHALL contain a REGS x N register file with register 0 reading as 0 and ignoring writes.
REQ-018 The module SHALL write wb_data to wb_addr on a rising edge when wb_en=1 and wb_addr is not 0.
REQ-019 The module SHALL transfer an input on a cycle where in_valid=1 and in_ready=1.
REQ-020 The module SHALL transfer an output on a cycle where out_valid=1 and out_ready=1.
REQ-021 The module SHALL hold a single output entry, with in_ready = (!out_valid or out_ready) and no interlock active.
REQ-022 The module SHALL capture into the output registers on an input transfer: A=R[rs1]; B=in_imm if in_use_imm else R[rs2]; ALUControl=in_aluctl; out_rd=in_rd; out_valid=1.
REQ-023 The module SHALL clear out_valid on an output transfer with no simultaneous input transfer.
REQ-024 The module SHALL hold A, B, ALUControl and out_rd stable while out_valid=1 and out_ready=0.
REQ-025 The module SHALL, when flush=1, force in_ready=0 and clear out_valid at the next edge; flush overrides all transfers.
REQ-026 The module SHALL have one cycle latency from input transfer to out_valid=1.
REQ-027 The module SHALL leave A, B, ALUControl and out_rd unchanged when out_valid is cleared.

Reset
REQ-028 The module SHALL, on rst=1 at a rising edge, set out_valid=0, A=0, B=0, ALUControl=00, out_rd=0, and all registers to 0.
REQ-029 The module SHALL give rst priority over flush, writeback and all transfers; in_ready SHALL be 0 while rst=1.

Configuration
REQ-030 The module SHALL, with macro EX_ISSUE_FWD_EN defined, bypass wb_data to any operand read whose address equals wb_addr (wb_en=1, address not 0) in the same cycle; the interlock is never active.
REQ-031 The module SHALL, without EX_ISSUE_FWD_EN, activate the interlock (in_ready=0) when wb_en=1 and wb_addr is not 0 and wb_addr equals in_rs1, or equals in_rs2 with in_use_imm=0.

Verification
REQ-032 Bench SHALL: wb R3=0x0000_0005, then issue rs1=3, imm=0x0000_0002, use_imm=1, aluctl=00 -> next cycle A=5, B=2, ALUControl=00, out_valid=1.
REQ-033 Bench SHALL: issue with out_ready=0 for 3 cycles -> A/B/out_rd stable, in_ready=0; out_ready=1 with a new input -> new input captured on the same edge, out_valid stays 1.
REQ-034 Bench SHALL: same-cycle wb R4=0xDEAD_BEEF and issue rs2=4 -> FWD_EN: B=0xDEAD_BEEF next cycle; without FWD_EN: in_ready=0 that cycle, then B=0xDEAD_BEEF after reissue.
REQ-035 Bench SHALL: wb R0=0xFFFF_FFFF, then issue rs1=0 -> A=0.
REQ-036 Bench SHALL: flush and in_valid asserted together while out_valid=1 -> out_valid=0 next cycle, input not accepted.
REQ-037 Bench SHALL: rst asserted mid-stall with out_valid=1 -> next cycle out_valid=0, outputs 0, reads of R1..R15 return 0.

Source files
------------

// File: rtl/ex_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : ex_issue_stage
// Brief    : Execute-issue stage. Holds a REGS x N register file, reads the
//            source operands of a decoded instruction, selects register or
//            immediate for operand B and registers the ALU operands into a
//            single-entry output buffer with a valid/ready handshake.
//            Optional feature macro: EX_ISSUE_FWD_EN
//              defined   - same-cycle writeback data is bypassed to operand
//                          reads, never stalling issue.
//              undefined - issue stalls (in_ready=0) while a same-cycle
//                          writeback targets a source register in use.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_issue_stage #(
  parameter int N    = 32,
  parameter int REGS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  // decoded instruction
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [((REGS > 1) ? $clog2(REGS) : 1)-1:0] in_rs1,
  input  logic [((REGS > 1) ? $clog2(REGS) : 1)-1:0] in_rs2,
  input  logic [((REGS > 1) ? $clog2(REGS) : 1)-1:0] in_rd,
  input  logic [N-1:0]                        in_imm,
  input  logic                                in_use_imm,
  input  logic [1:0]                          in_aluctl,
  // register writeback
  input  logic                                wb_en,
  input  logic [((REGS > 1) ? $clog2(REGS) : 1)-1:0] wb_addr,
  input  logic [N-1:0]                        wb_data,
  // issued instruction
  output logic [N-1:0]                        A,
  output logic [N-1:0]                        B,
  output logic [1:0]                          ALUControl,
  output logic [((REGS > 1) ? $clog2(REGS) : 1)-1:0] out_rd,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic                                flush
);

  localparam int AW = (REGS > 1) ? $clog2(REGS) : 1;

  // Upper bound used to make reads of non-existent registers return 0 when
  // REGS is not a power of two.
  localparam logic [AW:0] C_REGS = REGS[AW:0];

  // register file and output buffer state
  logic [N-1:0]  r_regs [REGS];
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [1:0]    r_aluctl;
  logic [AW-1:0] r_rd;
  logic          r_out_valid;

  // combinational datapath / control
  logic          w_wb_live;
  logic [N-1:0]  w_rs1_data;
  logic [N-1:0]  w_rs2_data;
  logic [N-1:0]  w_opb;
  logic          w_interlock;
  logic          w_in_xfer;
  logic          w_out_xfer;

  // A writeback only has effect when it targets a real, non-zero register.
  assign w_wb_live = wb_en && (wb_addr != '0);

  // Source operand reads; register 0 and out-of-range addresses read as 0.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if ((in_rs1 != '0) && ({1'b0, in_rs1} < C_REGS)) begin
      w_rs1_data = r_regs[in_rs1];
    end
    if ((in_rs2 != '0) && ({1'b0, in_rs2} < C_REGS)) begin
      w_rs2_data = r_regs[in_rs2];
    end
`ifdef EX_ISSUE_FWD_EN
    // Bypass the writeback landing on this same edge so the issued operand
    // already carries the new value.
    if (w_wb_live && (wb_addr == in_rs1)) begin
      w_rs1_data = wb_data;
    end
    if (w_wb_live && (wb_addr == in_rs2)) begin
      w_rs2_data = wb_data;
    end
`endif
  end

  // Operand B source select.
  assign w_opb = in_use_imm ? in_imm : w_rs2_data;

  // Hazard interlock against a same-cycle writeback to a source in use.
  always_comb begin
    w_interlock = 1'b0;
`ifndef EX_ISSUE_FWD_EN
    if (w_wb_live &&
        ((wb_addr == in_rs1) || (!in_use_imm && (wb_addr == in_rs2)))) begin
      w_interlock = 1'b1;
    end
`endif
  end

  // Single-entry buffer: accept when empty or draining, never during reset,
  // flush or an interlock.
  assign in_ready   = !rst && !flush && !w_interlock &&
                      (!r_out_valid || out_ready);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Register file: cleared on reset, written from the writeback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live && ({1'b0, wb_addr} < C_REGS)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Output buffer: capture on input transfer, invalidate on drain or flush;
  // payload is left untouched whenever valid is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_aluctl    <= 2'b00;
      r_rd        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_a         <= w_rs1_data;
      r_b         <= w_opb;
      r_aluctl    <= in_aluctl;
      r_rd        <= in_rd;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign ALUControl = r_aluctl;
  assign out_rd     = r_rd;
  assign out_valid  = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_issue_stage
// Brief    : Directed self-checking bench for ex_issue_stage (N=32, REGS=16).
//            Follows EX_ISSUE_FWD_EN for the writeback-hazard scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [3:0]  in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [1:0]  in_aluctl;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ALUControl;
  logic [3:0]  out_rd;
  logic        out_valid;
  logic        out_ready;
  logic        flush;

  int checks;
  int failures;

  ex_issue_stage #(.N(32), .REGS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_aluctl  (in_aluctl),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_rd     (out_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush)
  );

  // free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; return 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present an instruction on the input ports
  task automatic drive_in(input logic v, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [3:0] rd,
                          input logic [31:0] imm, input logic use_imm,
                          input logic [1:0] ctl);
    in_valid   = v;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_aluctl  = ctl;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = 4'd0;
    wb_data    = 32'd0;
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 2'b00);

    // reset state
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    rst = 1'b0;

    // write R3=5 and R15=0xA5A5A5A5, then issue rs1=3 with immediate 2
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h0000_0005;
    tick();
    wb_addr = 4'd15; wb_data = 32'hA5A5_A5A5;
    tick();
    wb_en = 1'b0;
    drive_in(1'b1, 4'd3, 4'd0, 4'd7, 32'h0000_0002, 1'b1, 2'b00);
    #1;
    chk("issue1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("issue1_A", A, 32'd5);
    chk("issue1_B", B, 32'd2);
    chk("issue1_ctl", {30'd0, ALUControl}, 32'd0);
    chk("issue1_rd", {28'd0, out_rd}, 32'd7);
    chk("issue1_valid", {31'd0, out_valid}, 32'd1);

    // stall three cycles with a new instruction pending
    drive_in(1'b1, 4'd0, 4'd0, 4'd2, 32'h0000_0009, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("stall_A", A, 32'd5);
      chk("stall_B", B, 32'd2);
      chk("stall_rd", {28'd0, out_rd}, 32'd7);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    // release: drain and capture on the same edge
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("capture_A", A, 32'd0);
    chk("capture_B", B, 32'd9);
    chk("capture_ctl", {30'd0, ALUControl}, 32'd3);
    chk("capture_rd", {28'd0, out_rd}, 32'd2);
    chk("capture_valid", {31'd0, out_valid}, 32'd1);
    // drain without new input: valid drops, payload kept
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_B_kept", B, 32'd9);
    out_ready = 1'b0;

    // top register readback
    drive_in(1'b1, 4'd15, 4'd0, 4'd15, 32'd0, 1'b1, 2'b00);
    tick();
    chk("r15_A", A, 32'hA5A5_A5A5);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;

    // writeback to a register only used as rs2 while immediate is selected,
    // or to R0, never stalls
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h1111_1111;
    drive_in(1'b0, 4'd0, 4'd4, 4'd0, 32'd0, 1'b1, 2'b00);
    #1;
    chk("no_hazard_imm", {31'd0, in_ready}, 32'd1);
    wb_addr = 4'd0;
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 2'b00);
    #1;
    chk("no_hazard_r0", {31'd0, in_ready}, 32'd1);

    // same-cycle writeback R4=0xDEADBEEF while issuing rs2=4
    wb_addr = 4'd4; wb_data = 32'hDEAD_BEEF;
    drive_in(1'b1, 4'd0, 4'd4, 4'd4, 32'd0, 1'b0, 2'b01);
    #1;
`ifdef EX_ISSUE_FWD_EN
    chk("hazard_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
    in_valid = 1'b0;
`else
    chk("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("hazard_not_taken", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b0;
    #1;
    chk("reissue_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
`endif
    chk("hazard_B", B, 32'hDEAD_BEEF);
    chk("hazard_ctl", {30'd0, ALUControl}, 32'd1);
    chk("hazard_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // writes to R0 are ignored
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_en = 1'b0;
    drive_in(1'b1, 4'd0, 4'd0, 4'd1, 32'd0, 1'b0, 2'b00);
    tick();
    chk("r0_A", A, 32'd0);
    chk("r0_B", B, 32'd0);
    chk("r0_valid", {31'd0, out_valid}, 32'd1);

    // flush with a pending input while holding a valid entry
    flush = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b1, 4'd3, 4'd0, 4'd9, 32'h0000_0011, 1'b1, 2'b10);
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rd_kept", {28'd0, out_rd}, 32'd1);
    chk("flush_A_kept", A, 32'd0);

    // reset in the middle of a stall
    drive_in(1'b1, 4'd3, 4'd0, 4'd6, 32'h0000_0022, 1'b1, 2'b11);
    tick();
    chk("prerst_valid", {31'd0, out_valid}, 32'd1);
    chk("prerst_A", A, 32'd5);
    tick();
    rst = 1'b1;
    #1;
    chk("inrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("postrst_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_A", A, 32'd0);
    chk("postrst_B", B, 32'd0);
    chk("postrst_ctl", {30'd0, ALUControl}, 32'd0);
    chk("postrst_rd", {28'd0, out_rd}, 32'd0);

    // every register reads back zero after reset
    out_ready = 1'b1;
    for (int r = 1; r < 16; r++) begin
      drive_in(1'b1, r[3:0], r[3:0], r[3:0], 32'd0, 1'b0, 2'b00);
      tick();
      chk($sformatf("postrst_R%0d_A", r), A, 32'd0);
      chk($sformatf("postrst_R%0d_B", r), B, 32'd0);
    end
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
